bip_control_unit: RTL

Instruction sequencer for the BIP processor. It drives the program-memory address (PC), captures the returned instruction word, and decodes the 5-bit opcode / 11-bit operand. It issues per-cycle control strobes to data memory, the accumulator and the ALU, and sits between the program memory and the accumulator datapath.

---
 rtl/bip_control_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bip_control_unit.sv
// BIP instruction sequencer: fetches, decodes and issues per-cycle datapath strobes.
// Optional macro BIP_ILLEGAL_OP_TRAP_EN: illegal opcodes halt with ILLEGAL set instead of acting as NOPs.
module bip_control_unit #(
    parameter logic [10:0] PC_START = 11'd0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [15:0]      PM_DATA,
    output logic [10:0]      PM_ADDR,
    output logic [10:0]      DM_ADDR,
    output logic             DM_WE,
    output logic             DM_RE,
    output logic [10:0]      OPERAND,
    output logic             ACC_WE,
    output logic [1:0]       ACC_SRC,
    output logic             ALU_B_SRC,
    output logic             ALU_OP,
    output logic             HALTED,
    output logic             ILLEGAL,
    output logic [CNT_W-1:0] CYCLE_COUNT
);

    localparam int unsigned PC_W = 11;
    localparam int unsigned IR_W = 16;
    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_HLT  = 5'd0;
    localparam logic [OP_W-1:0] OP_STO  = 5'd1;
    localparam logic [OP_W-1:0] OP_LD   = 5'd2;
    localparam logic [OP_W-1:0] OP_LDI  = 5'd3;
    localparam logic [OP_W-1:0] OP_ADD  = 5'd4;
    localparam logic [OP_W-1:0] OP_ADDI = 5'd5;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd6;
    localparam logic [OP_W-1:0] OP_SUBI = 5'd7;

    localparam logic [1:0] SRC_DMEM = 2'b00;
    localparam logic [1:0] SRC_IMM  = 2'b01;
    localparam logic [1:0] SRC_ALU  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    state_e           state_q;
    logic [PC_W-1:0]  pc_q;
    logic [IR_W-1:0]  ir_q;
    logic [CNT_W-1:0] cnt_q;

    logic [OP_W-1:0] opcode;
    logic            counting;
    logic            mem_rd_op;
    logic            trap;

    assign opcode    = ir_q[15:11];
    assign counting  = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                       (state_q == S_EXEC)  || (state_q == S_WB);
    assign mem_rd_op = (opcode == OP_LD) || (opcode == OP_ADD) || (opcode == OP_SUB);

`ifdef BIP_ILLEGAL_OP_TRAP_EN
    assign trap    = opcode[4] | opcode[3];
    assign ILLEGAL = (state_q == S_HALT) && trap;
`else
    assign trap    = 1'b0;
    assign ILLEGAL = 1'b0;
`endif

    assign PM_ADDR     = pc_q;
    assign DM_ADDR     = ir_q[10:0];
    assign OPERAND     = ir_q[10:0];
    assign HALTED      = (state_q == S_HALT);
    assign CYCLE_COUNT = cnt_q;

    // Sequencer: state, PC, IR and the saturating busy-cycle counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            pc_q    <= PC_START;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            if (counting && !(&cnt_q)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    ir_q    <= PM_DATA;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if ((opcode == OP_HLT) || trap) begin
                        state_q <= S_HALT;
                    end else begin
                        pc_q    <= pc_q + PC_W'(1);
                        state_q <= mem_rd_op ? S_WB : S_FETCH;
                    end
                end
                S_WB: begin
                    state_q <= S_FETCH;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Strobe and select decode from registered state and IR only.
    always_comb begin
        DM_WE     = 1'b0;
        DM_RE     = 1'b0;
        ACC_WE    = 1'b0;
        ACC_SRC   = SRC_DMEM;
        ALU_B_SRC = 1'b0;
        ALU_OP    = 1'b0;
        if (state_q == S_EXEC) begin
            case (opcode)
                OP_STO: DM_WE = 1'b1;
                OP_LDI: begin
                    ACC_WE  = 1'b1;
                    ACC_SRC = SRC_IMM;
                end
                OP_ADDI, OP_SUBI: begin
                    ACC_WE    = 1'b1;
                    ACC_SRC   = SRC_ALU;
                    ALU_B_SRC = 1'b1;
                    ALU_OP    = (opcode == OP_SUBI);
                end
                OP_LD, OP_ADD, OP_SUB: DM_RE = 1'b1;
                default: ;
            endcase
        end else if (state_q == S_WB) begin
            ACC_WE = 1'b1;
            if (opcode != OP_LD) begin
                ACC_SRC = SRC_ALU;
                ALU_OP  = (opcode == OP_SUB);
            end
        end
    end

endmodule
